irq_arbiter: RTL
================

// Module: irq_arbiter
// PURPOSE
//  Memory-mapped interrupt controller between interrupt sources (TC0 IRQ, TC1 IRQ, external interrupt, spares) and CPU hwInt.
//  Latches requests (edge or level per source), masks them and grants one source at a time.
//  Holds a one-hot request until the CPU acknowledges, then tracks in-service until software writes EOI.
//  Sits beside the timers on the bridge device bus; irq_vec drives cpu.hwInt[5:0].
// PARAMETERS
//  N_SRC  6  number of interrupt sources (1..8); must equal hwInt width when driving the CPU.
//  ID_W   3  width of the source id field; ceil(log2(N_SRC)), minimum 1.
// PORTS
//  clk      in   1      system clock.
//  reset    in   1      synchronous, active-high reset.
//  src_irq  in   N_SRC  raw interrupt lines; bit 0 = highest fixed priority.
//  Addr     in   30     word address from bridge, devAddr[31:2]; only Addr[3:2] decoded.
//  WE       in   1      register write enable, pre-decoded by bridge for this window.
//  Din      in   32     write data.
//  Dout     out  32     read data of the register selected by Addr[3:2]; combinational.
//  ack      in   1      CPU took the interrupt exception this cycle (one-cycle pulse).
//  irq_vec  out  N_SRC  one-hot granted request to the CPU; all zero when nothing is requested.
//  cur_id   out  ID_W   id of the granted or in-service source.
// BEHAVIOUR
//  Registers, selected by Addr[3:2]; all reset to 0:
//   - 0 MASK: RW, bits [N_SRC-1:0]; 1 = enabled.
//   - 1 PEND: R; write 1 clears edge-mode bits; level-mode bits ignore writes.
//   - 2 MODE: RW; 1 = edge-triggered, 0 = level.
//   - 3 CUR: R = {busy, 0..., cur_id}, where busy = (state != IDLE); any write = EOI.
//  Unused Dout bits read 0.
//  Capture, every cycle:
//   - Edge source: PEND set on a 0->1 of src_irq against its registered previous value.
//   - Level source: PEND = registered src_irq.
//   - Set and W1C on the same bit in the same cycle: set wins.
//  FSM states: IDLE, REQ, SERVICE.
//   - IDLE: if (PEND & MASK) != 0, pick winner, register grant id, go to REQ.
//   - REQ: irq_vec = onehot(grant); cur_id = grant.
//     - ack -> SERVICE; the edge PEND bit of grant clears; level bits are not cleared (the ISR clears the source).
//     - MASK[grant] cleared while no ack -> IDLE (request withdrawn). ack and mask-clear in the same cycle: ack wins.
//   - SERVICE: irq_vec = 0; cur_id held; new requests only accumulate in PEND; EOI write -> IDLE.
//   - EOI written outside SERVICE is ignored.
//  Latency: src_irq rises at cycle t; PEND is set at t+1; irq_vec is asserted at t+2 (registered, glitch-free).
//   - After EOI at cycle e, the next grant can be asserted at e+2.
//  Reset mid-operation: state returns to IDLE; MASK, PEND, MODE, the previous-src register, the grant and the round-robin pointer all clear.
//   - irq_vec and cur_id are 0 in the cycle after reset.
//  Indexes >= N_SRC: unused Din bits are ignored and read back as 0.
// CONFIGURATION
//  `IRQ_ROUND_ROBIN_EN defined:
//   - Winner = first pending & masked source strictly after the last acknowledged id, with wrap-around.
//   - The pointer updates on ack and resets to N_SRC-1, so bit 0 is first after reset.
//  Not defined: fixed priority, lowest index wins; no pointer register.
// STRUCTURE
//  const.v: register offsets (IRQ_MASK=2'd0, IRQ_PEND=2'd1, IRQ_MODE=2'd2, IRQ_CUR=2'd3) and FSM encodings (IRQ_IDLE, IRQ_REQ, IRQ_SVC).
//  Sub-module irq_pick: combinational picker.
//   - Inputs: req vector and ptr. Outputs: valid and id.
//   - Fixed and round-robin variants are selected by the macro.
// TESTING
//  1. Reset; MASK=6'h3f, MODE=6'h3f; pulse src_irq[1] for 1 cycle -> irq_vec=6'b000010 two cycles later; CUR=0x80000001.
//  2. With the grant pending, ack -> irq_vec=0 next cycle, PEND[1]=0. Write CUR (EOI) -> CUR=0, state IDLE.
//  3. Fixed priority: src_irq[2] and src_irq[0] rise together -> grant 0. After ack+EOI -> grant 2.
//     Round-robin (last ack=0): src 0 and 2 pending -> grant 2.
//  4. Level mode (MODE=0): hold src_irq[3] high through ack+EOI -> re-granted id 3. Drop src_irq[3] -> PEND[3]=0 after 1 cycle.
//  5. REQ on id 1; clear MASK[1] with no ack -> irq_vec=0 next cycle and PEND[1] stays 1. Same cycle with ack -> SERVICE.
//  6. Assert reset during SERVICE -> all registers 0, irq_vec=0. Edge on src_irq[0] the same cycle as W1C of PEND[0] -> PEND[0]=1.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// rtl/irq_arbiter_pkg.sv - register offsets and FSM encodings for irq_arbiter
package irq_arbiter_pkg;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_MODE = 2'd2;
  localparam logic [1:0] IRQ_CUR  = 2'd3;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_arbiter_pick.sv
// rtl/irq_arbiter_pick.sv - combinational winner picker; IRQ_ROUND_ROBIN_EN selects round-robin,
// otherwise lowest index wins and ptr is ignored.
module irq_arbiter_pick #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

`ifdef IRQ_ROUND_ROBIN_EN
  // Distance 0 is the source right after ptr; the smallest distance wins.
  always_comb begin : pick_rr
    int best;
    int d;
    best  = N_SRC;
    d     = 0;
    valid = 1'b0;
    id    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      d = (i + N_SRC - 1 - int'(ptr)) % N_SRC;
      if (req[i] && d < best) begin
        best  = d;
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - memory-mapped interrupt arbiter driving cpu hwInt; optional IRQ_ROUND_ROBIN_EN
// switches the picker from fixed priority to round-robin.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic             ack,
  output logic [N_SRC-1:0] irq_vec,
  output logic [ID_W-1:0]  cur_id
);

  irq_state_t       state;
  logic [N_SRC-1:0] mask, mode, pend, src_q;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  ptr;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;

  logic [N_SRC-1:0] din_bits, mask_nxt, pend_nxt, rise, w1c, ack_clr;
  logic             wr_mask, wr_pend, wr_mode, wr_cur, ack_now;

  logic unused_bits;
  assign unused_bits = ^{Addr[29:4], Addr[1:0], Din[31:N_SRC]};

  assign din_bits = Din[N_SRC-1:0];
  assign wr_mask  = WE && (Addr[3:2] == IRQ_MASK);
  assign wr_pend  = WE && (Addr[3:2] == IRQ_PEND);
  assign wr_mode  = WE && (Addr[3:2] == IRQ_MODE);
  assign wr_cur   = WE && (Addr[3:2] == IRQ_CUR);
  assign ack_now  = (state == IRQ_REQ) && ack;

  assign mask_nxt = wr_mask ? din_bits : mask;
  assign rise     = src_irq & ~src_q;
  assign w1c      = wr_pend ? din_bits : '0;
  assign ack_clr  = ack_now ? (N_SRC'(1) << grant) : '0;
  // Edge bits: a new rising edge beats any clear in the same cycle. Level bits track src_q.
  assign pend_nxt = (mode & ((pend & ~w1c & ~ack_clr) | rise)) | (~mode & src_irq);

  irq_arbiter_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .req   (pend & mask),
    .ptr   (ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

`ifdef IRQ_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)        ptr <= ID_W'(N_SRC - 1);
    else if (ack_now) ptr <= grant;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IRQ_IDLE;
      mask    <= '0;
      mode    <= '0;
      pend    <= '0;
      src_q   <= '0;
      grant   <= '0;
      irq_vec <= '0;
    end else begin
      src_q <= src_irq;
      mask  <= mask_nxt;
      pend  <= pend_nxt;
      if (wr_mode) mode <= din_bits;
      case (state)
        IRQ_IDLE: if (pick_valid) begin
          state   <= IRQ_REQ;
          grant   <= pick_id;
          irq_vec <= N_SRC'(1) << pick_id;
        end
        IRQ_REQ: if (ack) begin
          state   <= IRQ_SVC;
          irq_vec <= '0;
        end else if (!mask_nxt[grant]) begin
          state   <= IRQ_IDLE;
          grant   <= '0;
          irq_vec <= '0;
        end
        IRQ_SVC: if (wr_cur) begin
          state <= IRQ_IDLE;
          grant <= '0;
        end
        default: begin
          state   <= IRQ_IDLE;
          grant   <= '0;
          irq_vec <= '0;
        end
      endcase
    end
  end

  assign cur_id = grant;

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      IRQ_MASK: Dout[N_SRC-1:0] = mask;
      IRQ_PEND: Dout[N_SRC-1:0] = pend;
      IRQ_MODE: Dout[N_SRC-1:0] = mode;
      default: begin
        Dout[31]       = (state != IRQ_IDLE);
        Dout[ID_W-1:0] = grant;
      end
    endcase
  end

endmodule
